// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the M-extension multiply/divide unit.
// Holds the funct3/funct7 decode values and the FSM state encodings.
package muldiv_unit_pkg;

    localparam logic [6:0] OPCODE_ARITHMETIC = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV     = 7'b0000001;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_CALC = 2'd1;
    localparam logic [1:0] MD_FIX  = 2'd2;
    localparam logic [1:0] MD_DONE = 2'd3;

    function automatic logic rs1_is_signed(input logic [2:0] f3);
        return (f3 == FUNCT3_MULH) || (f3 == FUNCT3_MULHSU) ||
               (f3 == FUNCT3_DIV)  || (f3 == FUNCT3_REM);
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] f3);
        return (f3 == FUNCT3_MULH) || (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a shared accumulator.
// Multiply: acc = {partial_hi, multiplier}; divide: acc = {remainder, dividend/quotient}.
module muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic              is_div,
    input  logic [XLEN-1:0]   opnd,
    input  logic [2*XLEN-1:0] acc_in,
    output logic [2*XLEN-1:0] acc_out
);

    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] diff;
    logic            q_bit;

    always_comb begin
        add_sum = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, opnd} : '0);
        trial   = {acc_in[2*XLEN-1:XLEN], acc_in[XLEN-1]};
        q_bit   = trial >= {1'b0, opnd};
        // When the subtract succeeds the difference is below the divisor, so XLEN bits suffice.
        diff    = trial[XLEN-1:0] - opnd;
        if (is_div) begin
            acc_out = {(q_bit ? diff : trial[XLEN-1:0]), acc_in[XLEN-2:0], q_bit};
        end else begin
            acc_out = {add_sum, acc_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one radix-2 step per cycle,
// valid/ready on both sides, synchronous flush.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              s1, s2, in_div, div_zero, div_ovf;
    logic [XLEN-1:0]   mag1, mag2, special;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem, fixed;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (op_q[2]),
        .opnd    (opnd_q),
        .acc_in  (acc_q),
        .acc_out (acc_step)
    );

    always_comb begin
        s1       = rs1_is_signed(funct3) & rs1_data[XLEN-1];
        s2       = rs2_is_signed(funct3) & rs2_data[XLEN-1];
        mag1     = s1 ? -rs1_data : rs1_data;
        mag2     = s2 ? -rs2_data : rs2_data;
        in_div   = funct3[2];
        div_zero = in_div && (rs2_data == '0);
        div_ovf  = in_div && !funct3[0] && (rs1_data == MOST_NEG) && (rs2_data == '1);
        // funct3[1] separates REM/REMU from DIV/DIVU; overflowed DIV returns rs1 itself.
        if (div_zero) special = funct3[1] ? rs1_data : '1;
        else          special = funct3[1] ? '0 : rs1_data;

        prod = neg_res_q ? -acc_q : acc_q;
        quot = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            FUNCT3_MUL:                              fixed = prod[XLEN-1:0];
            FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: fixed = prod[2*XLEN-1:XLEN];
            FUNCT3_DIV, FUNCT3_DIVU:                 fixed = quot;
            default:                                 fixed = rem;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        if (flush) begin
            state_d = MD_IDLE;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (in_valid) begin
                        op_d      = funct3;
                        cnt_d     = '0;
                        neg_res_d = s1 ^ s2;
                        neg_rem_d = s1;
                        if (div_zero || div_ovf) begin
                            result_d = special;
                            state_d  = MD_DONE;
                        end else begin
                            opnd_d  = in_div ? mag2 : mag1;
                            acc_d   = {{XLEN{1'b0}}, (in_div ? mag1 : mag2)};
                            state_d = MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) state_d = MD_FIX;
                end
                MD_FIX: begin
                    result_d = fixed;
                    state_d  = MD_DONE;
                end
                MD_DONE: begin
                    if (out_ready) state_d = MD_IDLE;
                end
                default: state_d = MD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            op_q      <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign in_ready  = (state_q == MD_IDLE);
    assign out_valid = (state_q == MD_DONE);
    assign busy      = (state_q == MD_CALC) || (state_q == MD_DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, randomized ops against a
// 64-bit arithmetic reference, backpressure, flush and reset aborts.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        logic            ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = a;
        ub  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at #1 after a rising edge with the unit idle.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
        logic [31:0] exp;
        int          exp_lat;
        int          n;
        logic        saw_ready;
        exp     = ref_model(f3, a, b);
        exp_lat = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
                  ? 0 : 33;
        check({tag, " in_ready before"}, in_ready, 1);
        funct3    = f3;
        rs1_data  = a;
        rs2_data  = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        funct3   = 3'($urandom);
        rs1_data = $urandom;
        rs2_data = $urandom;
        n = 0;
        saw_ready = 1'b0;
        while (!out_valid && n < 200) begin
            saw_ready |= in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, n, exp_lat);
        check({tag, " in_ready while busy"}, saw_ready | in_ready, 0);
        check({tag, " result"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " held {out_valid,in_ready,result}"}, {out_valid, in_ready, result},
                  {1'b1, 1'b0, exp});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " after handshake {out_valid,in_ready}"}, {out_valid, in_ready}, 2'b01);
        out_ready = 1'b0;
    endtask

    task automatic start_div_and_wait(input int iters);
        funct3   = 3'b100;
        rs1_data = 32'd1000;
        rs2_data = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (iters) @(posedge clk);
        #1;
    endtask

    initial begin
        logic        saw_valid;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;

        repeat (2) @(posedge clk);
        #1;
        check("reset {in_ready,out_valid,busy,result}", {in_ready, out_valid, busy, result},
              {1'b1, 1'b0, 1'b0, 32'h0});
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_op("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 0);
        do_op("MULH", 3'b001, 32'h8000_0000, 32'h8000_0000, 0);
        do_op("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("DIVU 100/7", 3'b101, 32'd100, 32'd7, 0);
        do_op("REMU 100/7", 3'b111, 32'd100, 32'd7, 0);
        do_op("DIV 5/0", 3'b100, 32'd5, 32'd0, 0);
        do_op("REM 5/0", 3'b110, 32'd5, 32'd0, 0);
        do_op("DIVU 5/0", 3'b101, 32'd5, 32'd0, 0);
        do_op("REMU 5/0", 3'b111, 32'd5, 32'd0, 0);
        do_op("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("MULH backpressure", 3'b001, 32'h1234_5678, 32'hFEDC_BA98, 5);

        // Flush at iteration 10 of a divide.
        start_div_and_wait(10);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush {in_ready,out_valid,busy}", {in_ready, out_valid, busy}, 3'b100);
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            saw_valid |= out_valid;
        end
        check("flush no out_valid", saw_valid, 0);
        do_op("MUL 3*4 after flush", 3'b000, 32'd3, 32'd4, 0);

        // Flush with a request in IDLE drops it.
        funct3   = 3'b000;
        rs1_data = 32'd9;
        rs2_data = 32'd9;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush+in_valid {in_ready,busy}", {in_ready, busy}, 2'b10);
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            saw_valid |= out_valid | busy;
        end
        check("dropped request no activity", saw_valid, 0);

        // Reset mid-CALC; result from the previous MUL was nonzero.
        start_div_and_wait(10);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid-CALC reset {in_ready,out_valid,busy,result}",
              {in_ready, out_valid, busy, result}, {1'b1, 1'b0, 1'b0, 32'h0});
        do_op("MUL 3*4 after reset", 3'b000, 32'd3, 32'd4, 0);

        for (int i = 0; i < 48; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: b = -$urandom_range(1, 15);
                default: ;
            endcase
            do_op("random", f3, a, b, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
